powerup_bank: RTL and testbench
===============================

// Module: powerup_bank
// PURPOSE
//  Parametrised bank of N collectible power-ups (flower/mushroom-class objects) in world coordinates.
//  Each slot stays hidden until revealed, then rises out of its block and becomes collectible.
//  Collects on character bounding-box overlap and reports one collection per cycle to the game logic.
//  Drives screen-space coordinates and enables to the sprite renderer.
//  Sits in game_calc/objects beside the other object blocks.
// PARAMETERS
//  N_ITEMS      4                 number of power-up slots (1..16)
//  COORD_W      10                coordinate width in bits
//  ITEM_SIZE    12                item box edge, pixels; also total rise height
//  CHAR_SIZE    12                character box edge, pixels
//  RISE_STEP    1                 pixels risen per tick pulse
//  ITEM_X_INIT  {4{10'd272}}      packed N*COORD_W world X per slot; slot i = bits [i*W +: W]
//  ITEM_Y_INIT  {4{10'd135}}      packed N*COORD_W final (risen) world Y per slot
// PORTS
//  sys_clk         in   1          system clock
//  RST_N           in   1          asynchronous active-low reset
//  char_x          in   COORD_W    character world X (top-left)
//  char_y          in   COORD_W    character world Y (top-left)
//  bg_pos          in   COORD_W    camera scroll offset
//  reveal          in   N_ITEMS    per-slot one-cycle pulse: block under slot was hit
//  tick            in   1          frame-rate strobe that paces the rise animation
//  item_x          out  N*COORD_W  screen X per slot = world X - bg_pos, modulo 2^COORD_W
//  item_y          out  N*COORD_W  current world Y per slot
//  item_en         out  N_ITEMS    slot is visible (RISING or ACTIVE)
//  touch           out  1          one-cycle registered pulse: a slot was collected
//  touch_id        out  $clog2(N)  index of the collected slot; valid while touch=1, else holds last value
//  collected_mask  out  N_ITEMS    sticky: slot has been collected
// BEHAVIOUR
//  Reset values: all slots HIDDEN; item_y[i] = Y_INIT[i] + ITEM_SIZE; item_en = 0; touch = 0;
//   touch_id = 0; collected_mask = 0.
//  Per-slot FSM:
//   HIDDEN    -> RISING on reveal[i]=1 (registered; item_en rises next cycle)
//   RISING    -> y decrements by RISE_STEP on each tick; moves to ACTIVE on the tick that
//                reaches Y_INIT (clamped, never overshoots); not collectible while RISING
//   ACTIVE    -> COLLECTED when overlap=1 AND the slot is granted by the arbiter
//   COLLECTED -> terminal until reset; reveal is ignored
//  Additional reveal pulses outside HIDDEN are ignored.
//  Overlap is inclusive AABB on both axes, computed at COORD_W+1 bits so sums never wrap:
//   char_x <= ix+ITEM_SIZE && char_x+CHAR_SIZE >= ix; same form for Y.
//   Boxes that only touch at an edge count as overlapping.
//  Arbitration:
//   - Candidate set = ACTIVE slots with overlap=1. The lowest index wins.
//   - In the next cycle the winner goes to COLLECTED, touch=1, touch_id=winner, and collected_mask[winner] sets.
//   - Losers stay ACTIVE and win in following cycles, so k overlapping slots give k consecutive touch pulses.
//  Latency: overlap input to touch = 1 cycle.
//  Rendering: item_x is combinational from the stored world X and bg_pos.
//   Wrap-around is allowed; the renderer clips.
//  Simultaneous events on one slot in the same cycle:
//   - reveal and tick in HIDDEN: only the transition to RISING happens; y is unchanged.
//   - tick in the last RISING step: the slot is ACTIVE the next cycle and is collectible from then on.
//  Reset mid-operation (any state): the slot returns to HIDDEN and any pending touch is dropped.
//  N_ITEMS=1: touch_id is 1 bit wide and tied to 0.
// STRUCTURE
//  powerup_pkg:
//   - slot state enum (HIDDEN=2'd0, RISING=2'd1, ACTIVE=2'd2, COLLECTED=2'd3)
//   - the AABB overlap function
//   - the clog2 helper
//  powerup_slot (sub-module, generated N_ITEMS times): state, Y register, rise logic, overlap,
//   collect request out, grant in.
//  The top level contains the priority arbiter, touch/touch_id registers and screen-X subtractors.
// TESTING
//  1. Reset, then char at (272,135) with no reveal -> touch stays 0, item_en=0 (hidden slots are not collectible).
//  2. Reveal slot0 and apply 12 ticks -> item_y[0] steps 147..135, item_en[0]=1;
//     ACTIVE after the 12th tick; char overlaps at tick 6 -> no touch.
//  3. Slot0 ACTIVE, char moves to (260,123) (edge contact) -> touch=1 for exactly one cycle,
//     touch_id=0, collected_mask=0001; a second overlap causes no further touch.
//  4. Slots 1 and 2 at the same position, both ACTIVE, char overlapping -> touch on two consecutive cycles,
//     touch_id=1 then 2, collected_mask=0111.
//  5. bg_pos=300, world X=272 -> item_x=10'd996 (wrapped). char_x=1020 -> no false overlap
//     (checks the COORD_W+1 arithmetic).
//  6. Assert RST_N low mid-RISING, and again while touch=1 -> all outputs return to reset values
//     asynchronously; a fresh reveal after reset restarts the rise.

Source files
------------

// File: rtl/powerup_pkg.sv
// Shared types and helpers for the power-up object bank.
// No logic of its own; latency and backpressure are defined by the users.
// Overlap function zero-extends to MAXW+1 bits so coordinate sums never wrap.
package powerup_pkg;

    typedef enum logic [1:0] {
        HIDDEN    = 2'd0,
        RISING    = 2'd1,
        ACTIVE    = 2'd2,
        COLLECTED = 2'd3
    } slot_state_e;

    // Widest coordinate supported; overlap maths runs at MAXW+1 bits.
    localparam int MAXW = 16;

    // Index width that never collapses to zero (a single slot still gets one bit).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Inclusive AABB test; edge contact counts as overlap.
    function automatic logic aabb_overlap(input logic [MAXW:0] cx, input logic [MAXW:0] cy,
                                          input logic [MAXW:0] ix, input logic [MAXW:0] iy,
                                          input int isz, input int csz);
        logic [MAXW:0] is_v;
        logic [MAXW:0] cs_v;
        is_v = isz[MAXW:0];
        cs_v = csz[MAXW:0];
        return (cx <= ix + is_v) && (cx + cs_v >= ix) &&
               (cy <= iy + is_v) && (cy + cs_v >= iy);
    endfunction

endpackage

// File: rtl/powerup_bank_if.sv
// Bundle between the game logic / renderer and the power-up bank.
// Pure wiring, no latency.
// No backpressure: touch is a single-cycle pulse the game logic must consume.
interface powerup_bank_if #(
    parameter int N_ITEMS = 4,
    parameter int COORD_W = 10
) ();
    import powerup_pkg::*;

    localparam int ID_W = clog2(N_ITEMS);

    logic [COORD_W-1:0]         char_x;
    logic [COORD_W-1:0]         char_y;
    logic [COORD_W-1:0]         bg_pos;
    logic [N_ITEMS-1:0]         reveal;
    logic                       tick;
    logic [N_ITEMS*COORD_W-1:0] item_x;
    logic [N_ITEMS*COORD_W-1:0] item_y;
    logic [N_ITEMS-1:0]         item_en;
    logic                       touch;
    logic [ID_W-1:0]            touch_id;
    logic [N_ITEMS-1:0]         collected_mask;

    modport master (
        output char_x, char_y, bg_pos, reveal, tick,
        input  item_x, item_y, item_en, touch, touch_id, collected_mask
    );

    modport slave (
        input  char_x, char_y, bg_pos, reveal, tick,
        output item_x, item_y, item_en, touch, touch_id, collected_mask
    );
endinterface

// File: rtl/powerup_slot.sv
// One power-up slot: hidden/rising/active/collected state, Y position and overlap request.
// State and Y update one cycle after reveal/tick/grant; req is combinational.
// No backpressure: a requesting slot simply waits until the arbiter grants it.
module powerup_slot
    import powerup_pkg::*;
#(
    parameter int                 COORD_W   = 10,
    parameter int                 ITEM_SIZE = 12,
    parameter int                 CHAR_SIZE = 12,
    parameter int                 RISE_STEP = 1,
    parameter logic [COORD_W-1:0] X_INIT    = '0,
    parameter logic [COORD_W-1:0] Y_INIT    = '0
) (
    input  logic               sys_clk,
    input  logic               RST_N,
    input  logic [COORD_W-1:0] char_x,
    input  logic [COORD_W-1:0] char_y,
    input  logic               reveal,
    input  logic               tick,
    input  logic               grant,
    output logic               req,
    output logic               en,
    output logic               collected,
    output logic [COORD_W-1:0] y_out
);
    localparam logic [COORD_W-1:0] Y_START = COORD_W'(int'(Y_INIT) + ITEM_SIZE);
    localparam logic [COORD_W:0]   Y_DONE  = {1'b0, Y_INIT} + (COORD_W+1)'(RISE_STEP);

    slot_state_e        state_q, state_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [MAXW:0]      cx_ext, cy_ext, ix_ext, iy_ext;
    logic               overlap;

    assign cx_ext  = {{(MAXW+1-COORD_W){1'b0}}, char_x};
    assign cy_ext  = {{(MAXW+1-COORD_W){1'b0}}, char_y};
    assign ix_ext  = {{(MAXW+1-COORD_W){1'b0}}, X_INIT};
    assign iy_ext  = {{(MAXW+1-COORD_W){1'b0}}, y_q};
    assign overlap = aabb_overlap(cx_ext, cy_ext, ix_ext, iy_ext, ITEM_SIZE, CHAR_SIZE);

    // Next state and Y: reveal starts the rise, ticks step Y up to its clamped final position.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        case (state_q)
            HIDDEN: begin
                if (reveal) state_d = RISING;
            end
            RISING: begin
                if (tick) begin
                    if ({1'b0, y_q} <= Y_DONE) begin
                        y_d     = Y_INIT;
                        state_d = ACTIVE;
                    end else begin
                        y_d = y_q - COORD_W'(RISE_STEP);
                    end
                end
            end
            ACTIVE: begin
                if (grant) state_d = COLLECTED;
            end
            default: state_d = COLLECTED;
        endcase
    end

    // State and Y registers.
    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= HIDDEN;
            y_q     <= Y_START;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign req       = (state_q == ACTIVE) && overlap;
    assign en        = (state_q == RISING) || (state_q == ACTIVE);
    assign collected = (state_q == COLLECTED);
    assign y_out     = y_q;

endmodule

// File: rtl/powerup_bank.sv
// Bank of N_ITEMS power-up slots with lowest-index-first collection arbiter.
// Overlap to touch pulse is 1 cycle; item_x is combinational from bg_pos.
// No backpressure: overlapping slots are granted one per cycle, losers retry next cycle.
module powerup_bank
    import powerup_pkg::*;
#(
    parameter int                         N_ITEMS     = 4,
    parameter int                         COORD_W     = 10,
    parameter int                         ITEM_SIZE   = 12,
    parameter int                         CHAR_SIZE   = 12,
    parameter int                         RISE_STEP   = 1,
    parameter logic [N_ITEMS*COORD_W-1:0] ITEM_X_INIT = {N_ITEMS{COORD_W'(272)}},
    parameter logic [N_ITEMS*COORD_W-1:0] ITEM_Y_INIT = {N_ITEMS{COORD_W'(135)}}
) (
    input  logic           sys_clk,
    input  logic           RST_N,
    powerup_bank_if.slave  bus
);
    localparam int ID_W = clog2(N_ITEMS);

    logic [N_ITEMS-1:0]         req, grant, en_w, coll_w;
    logic [N_ITEMS*COORD_W-1:0] item_x_w, item_y_w;
    logic                       touch_q, touch_d;
    logic [ID_W-1:0]            touch_id_q, touch_id_d;
    logic [ID_W-1:0]            win;
    logic                       found;

    for (genvar i = 0; i < N_ITEMS; i++) begin : g_slot
        localparam logic [COORD_W-1:0] XI = ITEM_X_INIT[i*COORD_W +: COORD_W];
        localparam logic [COORD_W-1:0] YI = ITEM_Y_INIT[i*COORD_W +: COORD_W];

        powerup_slot #(
            .COORD_W   (COORD_W),
            .ITEM_SIZE (ITEM_SIZE),
            .CHAR_SIZE (CHAR_SIZE),
            .RISE_STEP (RISE_STEP),
            .X_INIT    (XI),
            .Y_INIT    (YI)
        ) u_slot (
            .sys_clk   (sys_clk),
            .RST_N     (RST_N),
            .char_x    (bus.char_x),
            .char_y    (bus.char_y),
            .reveal    (bus.reveal[i]),
            .tick      (bus.tick),
            .grant     (grant[i]),
            .req       (req[i]),
            .en        (en_w[i]),
            .collected (coll_w[i]),
            .y_out     (item_y_w[i*COORD_W +: COORD_W])
        );

        // Screen X wraps modulo 2^COORD_W; the renderer clips.
        assign item_x_w[i*COORD_W +: COORD_W] = XI - bus.bg_pos;
    end

    // Priority arbiter: lowest requesting index is granted; touch_id holds when idle.
    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
                win      = ID_W'(i);
            end
        end
        touch_d    = found;
        touch_id_d = found ? win : touch_id_q;
    end

    // Registered touch pulse and winning index.
    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            touch_q    <= 1'b0;
            touch_id_q <= '0;
        end else begin
            touch_q    <= touch_d;
            touch_id_q <= touch_id_d;
        end
    end

    assign bus.item_x         = item_x_w;
    assign bus.item_y         = item_y_w;
    assign bus.item_en        = en_w;
    assign bus.touch          = touch_q;
    assign bus.touch_id       = touch_id_q;
    assign bus.collected_mask = coll_w;

endmodule

// File: tb/tb_powerup_bank.sv
// Directed bench for powerup_bank with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// Async reset is checked between clock edges.
module tb_powerup_bank;

    logic sys_clk;
    logic RST_N;
    int   vecs;
    int   errs;

    powerup_bank_if #(.N_ITEMS(4), .COORD_W(10)) bus ();

    powerup_bank #(.N_ITEMS(4), .COORD_W(10)) dut (
        .sys_clk (sys_clk),
        .RST_N   (RST_N),
        .bus     (bus.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    task automatic pulse_reveal(input logic [3:0] m);
        bus.reveal = m;
        step();
        bus.reveal = 4'b0;
    endtask

    function automatic logic [9:0] yof(input int i);
        return bus.item_y[i*10 +: 10];
    endfunction

    function automatic logic [9:0] xof(input int i);
        return bus.item_x[i*10 +: 10];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},    64'(bus.item_en), 64'd0);
        check({tag, "_touch"}, 64'(bus.touch), 64'd0);
        check({tag, "_id"},    64'(bus.touch_id), 64'd0);
        check({tag, "_mask"},  64'(bus.collected_mask), 64'd0);
        check({tag, "_y0"},    64'(yof(0)), 64'd147);
        check({tag, "_y3"},    64'(yof(3)), 64'd147);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        RST_N      = 1'b0;
        bus.char_x = 10'd0;
        bus.char_y = 10'd0;
        bus.bg_pos = 10'd0;
        bus.reveal = 4'b0;
        bus.tick   = 1'b0;
        #12;
        check_reset_outputs("rst");
        check("rst_x0", 64'(xof(0)), 64'd272);
        RST_N = 1'b1;
        step();

        // 1: hidden slots are not collectible
        bus.char_x = 10'd272;
        bus.char_y = 10'd135;
        step(); step();
        check("t1_touch", 64'(bus.touch), 64'd0);
        check("t1_en",    64'(bus.item_en), 64'd0);

        // 2: reveal slot0 and rise; overlap while rising must not collect
        pulse_reveal(4'b0001);
        check("t2_en",    64'(bus.item_en), 64'd1);
        check("t2_y_rev", 64'(yof(0)), 64'd147);
        for (int k = 1; k <= 6; k++) begin
            pulse_tick();
            check("t2_y", 64'(yof(0)), 64'(147 - k));
        end
        step();
        check("t2_touch_rising", 64'(bus.touch), 64'd0);
        bus.char_x = 10'd0;
        bus.char_y = 10'd0;
        for (int k = 7; k <= 12; k++) begin
            pulse_tick();
            check("t2_y", 64'(yof(0)), 64'(147 - k));
        end
        pulse_tick();
        check("t2_y_clamped", 64'(yof(0)), 64'd135);
        check("t2_touch_end", 64'(bus.touch), 64'd0);

        // 3: edge contact collects slot0 exactly once
        bus.char_x = 10'd260;
        bus.char_y = 10'd123;
        step();
        check("t3_touch", 64'(bus.touch), 64'd1);
        check("t3_id",    64'(bus.touch_id), 64'd0);
        check("t3_mask",  64'(bus.collected_mask), 64'b0001);
        check("t3_en",    64'(bus.item_en), 64'd0);
        step();
        check("t3_touch_once", 64'(bus.touch), 64'd0);
        step();
        check("t3_touch_again", 64'(bus.touch), 64'd0);

        // 4: two overlapping active slots give two consecutive touches
        bus.char_x = 10'd0;
        bus.char_y = 10'd0;
        pulse_reveal(4'b0110);
        for (int k = 0; k < 12; k++) pulse_tick();
        check("t4_y1", 64'(yof(1)), 64'd135);
        check("t4_y2", 64'(yof(2)), 64'd135);
        check("t4_en", 64'(bus.item_en), 64'b0110);
        bus.char_x = 10'd272;
        bus.char_y = 10'd135;
        step();
        check("t4_touch_a", 64'(bus.touch), 64'd1);
        check("t4_id_a",    64'(bus.touch_id), 64'd1);
        check("t4_mask_a",  64'(bus.collected_mask), 64'b0011);
        step();
        check("t4_touch_b", 64'(bus.touch), 64'd1);
        check("t4_id_b",    64'(bus.touch_id), 64'd2);
        check("t4_mask_b",  64'(bus.collected_mask), 64'b0111);
        step();
        check("t4_touch_c", 64'(bus.touch), 64'd0);
        check("t4_id_hold", 64'(bus.touch_id), 64'd2);

        // 5: screen X wrap and no false overlap near the top of the range
        bus.bg_pos = 10'd300;
        #1;
        check("t5_x3", 64'(xof(3)), 64'd996);
        bus.char_x = 10'd1020;
        pulse_reveal(4'b1000);
        for (int k = 0; k < 12; k++) pulse_tick();
        step();
        check("t5_en",       64'(bus.item_en), 64'b1000);
        check("t5_no_touch", 64'(bus.touch), 64'd0);
        bus.char_x = 10'd272;
        step();
        check("t5_touch", 64'(bus.touch), 64'd1);
        check("t5_id",    64'(bus.touch_id), 64'd3);
        check("t5_mask",  64'(bus.collected_mask), 64'b1111);
        bus.bg_pos = 10'd0;

        // 6a: async reset drops everything between edges
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("t6a");
        RST_N = 1'b1;
        bus.char_x = 10'd0;
        bus.char_y = 10'd0;
        step();

        // 6b: reset mid-rising
        pulse_reveal(4'b0001);
        pulse_tick(); pulse_tick(); pulse_tick();
        check("t6b_y", 64'(yof(0)), 64'd144);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("t6b");
        RST_N = 1'b1;
        step();

        // 6c: reset while touch is high
        pulse_reveal(4'b0001);
        for (int k = 0; k < 12; k++) pulse_tick();
        bus.char_x = 10'd272;
        bus.char_y = 10'd135;
        step();
        check("t6c_touch_pre", 64'(bus.touch), 64'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("t6c");
        RST_N = 1'b1;
        bus.char_x = 10'd0;
        bus.char_y = 10'd0;
        step();

        // 6d: fresh reveal with a simultaneous tick leaves Y unchanged, then rises
        bus.tick = 1'b1;
        pulse_reveal(4'b0001);
        bus.tick = 1'b0;
        check("t6d_en", 64'(bus.item_en), 64'b0001);
        check("t6d_y",  64'(yof(0)), 64'd147);
        pulse_tick();
        check("t6d_y_step", 64'(yof(0)), 64'd146);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
